// File: rtl/unread_compactor.sv
// Sink for otherwise-unused buses. Every enabled cycle, the input channels are
// folded into a multiple-input signature register (MISR).
// Optional toggle monitoring is built only when UNREAD_COMPACTOR_TOGGLE_EN is defined.
// Without it, toggle_cnt_o and active_o are tied to zero and the port list is unchanged.
module unread_compactor #(
    parameter int unsigned          WIDTH     = 32,
    parameter int unsigned          CHANNELS  = 1,
    parameter int unsigned          SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(32'h04C11DB7),
    parameter logic [SIG_WIDTH-1:0] SEED      = '0,
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         clear_i,
    input  logic [CHANNELS*WIDTH-1:0]    d_i,
    output logic [SIG_WIDTH-1:0]         signature_o,
    output logic [CNT_WIDTH-1:0]         toggle_cnt_o,
    output logic                         active_o
);

    localparam int unsigned DataW  = CHANNELS * WIDTH;
    localparam int unsigned NSlice = (WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
    localparam int unsigned PadW   = NSlice * SIG_WIDTH;

    logic [WIDTH-1:0]     ch;
    logic [PadW-1:0]      ch_pad;
    logic [SIG_WIDTH-1:0] fold;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;

    // Fold the channels together, then fold the result down to the signature width.
    always_comb begin
        ch = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            ch = ch ^ d_i[k*WIDTH +: WIDTH];
        end
        ch_pad = '0;
        ch_pad[WIDTH-1:0] = ch;
        fold = '0;
        for (int unsigned j = 0; j < NSlice; j++) begin
            fold = fold ^ ch_pad[j*SIG_WIDTH +: SIG_WIDTH];
        end
    end

    // MISR next state. A clear discards that cycle's data.
    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = (sig_q << 1) ^ (sig_q[SIG_WIDTH-1] ? POLY : '0) ^ fold;
        end
    end

    // Signature register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature_o = sig_q;

`ifdef UNREAD_COMPACTOR_TOGGLE_EN
    logic [DataW-1:0]     prev_q, prev_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 active_q, active_d;
    logic                 toggle;

    // Compare against the last enabled sample; the counter saturates instead of wrapping.
    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        toggle       = prev_valid_q && (d_i != prev_q);
        if (clear_i) begin
            prev_d       = '0;
            prev_valid_d = 1'b0;
            cnt_d        = '0;
            active_d     = 1'b0;
        end else if (en_i) begin
            prev_d       = d_i;
            prev_valid_d = 1'b1;
            if (toggle) begin
                if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
                active_d = 1'b1;
            end
        end
    end

    // Toggle monitor state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            cnt_q        <= '0;
            active_q     <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
        end
    end

    assign toggle_cnt_o = cnt_q;
    assign active_o     = active_q;
`else
    assign toggle_cnt_o = '0;
    assign active_o     = 1'b0;
`endif

endmodule

// File: tb/tb_unread_compactor.sv
// Scoreboard bench for unread_compactor.
// Instance A uses WIDTH=16, CHANNELS=2 and SIG_WIDTH=8, so its width fold takes the slicing path.
// Instance B uses WIDTH=8, CHANNELS=3 and SIG_WIDTH=13, so its width fold takes the zero-extend path.
module tb_unread_compactor;

`ifdef UNREAD_COMPACTOR_TOGGLE_EN
    localparam bit ToggleEn = 1'b1;
`else
    localparam bit ToggleEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, en;
    logic [31:0] d_a;
    logic [23:0] d_b;
    logic [7:0]  sig_a;
    logic [3:0]  cnt_a;
    logic        act_a;
    logic [12:0] sig_b;
    logic [2:0]  cnt_b;
    logic        act_b;

    unread_compactor #(
        .WIDTH(16), .CHANNELS(2), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .CNT_WIDTH(4)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .d_i(d_a),
        .signature_o(sig_a), .toggle_cnt_o(cnt_a), .active_o(act_a)
    );

    unread_compactor #(
        .WIDTH(8), .CHANNELS(3), .SIG_WIDTH(13), .POLY(13'h1DB7), .SEED(13'h0A5A),
        .CNT_WIDTH(3)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .d_i(d_b),
        .signature_o(sig_b), .toggle_cnt_o(cnt_b), .active_o(act_b)
    );

    typedef struct {
        logic [63:0] sig_a, cnt_a, act_a, sig_b, cnt_b, act_b;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Per-instance configuration and reference model state.
    int unsigned cfg_w[2], cfg_c[2], cfg_s[2], cfg_cw[2];
    logic [63:0] cfg_poly[2], cfg_seed[2];
    logic [63:0] m_sig[2], m_prev[2], m_cnt[2];
    bit          m_pv[2], m_act[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int unsigned n);
        return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic void model_update(input int i, input bit r, input bit c, input bit e,
                                         input logic [63:0] d);
        logic [63:0] ch, f, dm;
        bit          tog;
        if (r || c) begin
            m_sig[i]  = cfg_seed[i] & mask(cfg_s[i]);
            m_prev[i] = '0;
            m_pv[i]   = 1'b0;
            m_cnt[i]  = '0;
            m_act[i]  = 1'b0;
        end else if (e) begin
            dm = d & mask(cfg_c[i] * cfg_w[i]);
            ch = '0;
            for (int k = 0; k < int'(cfg_c[i]); k++) begin
                ch = ch ^ ((dm >> (k * cfg_w[i])) & mask(cfg_w[i]));
            end
            f = '0;
            for (int j = 0; j < int'(cfg_w[i]); j += int'(cfg_s[i])) begin
                f = f ^ ((ch >> j) & mask(cfg_s[i]));
            end
            m_sig[i] = ((m_sig[i] << 1) & mask(cfg_s[i]))
                     ^ (m_sig[i][cfg_s[i]-1] ? (cfg_poly[i] & mask(cfg_s[i])) : 64'd0) ^ f;
            tog = m_pv[i] && (dm != m_prev[i]);
            m_prev[i] = dm;
            m_pv[i]   = 1'b1;
            if (tog) begin
                if (m_cnt[i] != mask(cfg_cw[i])) m_cnt[i] = m_cnt[i] + 64'd1;
                m_act[i] = 1'b1;
            end
        end
    endfunction

    // Called at a falling edge: drive the inputs, push the expected result,
    // then compare one step after the rising edge.
    task automatic step(input bit r, input bit c, input bit e, input logic [31:0] da,
                        input logic [23:0] db);
        exp_t x, y;
        rst = r; clr = c; en = e; d_a = da; d_b = db;
        model_update(0, r, c, e, {32'd0, da});
        model_update(1, r, c, e, {40'd0, db});
        x.sig_a = m_sig[0];
        x.cnt_a = ToggleEn ? m_cnt[0] : 64'd0;
        x.act_a = ToggleEn ? 64'(m_act[0]) : 64'd0;
        x.sig_b = m_sig[1];
        x.cnt_b = ToggleEn ? m_cnt[1] : 64'd0;
        x.act_b = ToggleEn ? 64'(m_act[1]) : 64'd0;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        check_eq("sig_a", 64'(sig_a), y.sig_a);
        check_eq("cnt_a", 64'(cnt_a), y.cnt_a);
        check_eq("act_a", 64'(act_a), y.act_a);
        check_eq("sig_b", 64'(sig_b), y.sig_b);
        check_eq("cnt_b", 64'(cnt_b), y.cnt_b);
        check_eq("act_b", 64'(act_b), y.act_b);
        @(negedge clk);
    endtask

    logic [31:0] last_d;

    initial begin
        cfg_w  = '{16, 8};  cfg_c = '{2, 3};  cfg_s = '{8, 13};  cfg_cw = '{4, 3};
        cfg_poly = '{64'h1D, 64'h1DB7};
        cfg_seed = '{64'h00, 64'h0A5A};
        for (int i = 0; i < 2; i++) begin
            m_sig[i] = '0; m_prev[i] = '0; m_cnt[i] = '0; m_pv[i] = 0; m_act[i] = 0;
        end
        rst = 1'b1; clr = 1'b0; en = 1'b0; d_a = '0; d_b = '0;
        @(negedge clk);

        // Reset state.
        step(1, 0, 1, 32'hDEADBEEF, 24'hABCDEF);
        check_eq("rst_sig_a", 64'(sig_a), 64'h00);
        check_eq("rst_sig_b", 64'(sig_b), 64'h0A5A);
        check_eq("rst_cnt_a", 64'(cnt_a), 64'd0);

        // Basic MISR sequence.
        step(0, 0, 1, 32'h01, 24'h01);
        check_eq("basic0", 64'(sig_a), 64'h01);
        step(0, 0, 1, 32'h80, 24'h80);
        check_eq("basic1", 64'(sig_a), 64'h82);
        step(0, 0, 1, 32'h00, 24'h00);
        check_eq("basic2", 64'(sig_a), 64'h19);

        // Identical channels cancel.
        step(0, 1, 1, 32'h0, 24'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 32'hAAAA_AAAA, 24'hAAAAAA);
            check_eq("cancel", 64'(sig_a), 64'h00);
        end

        // Width fold.
        step(0, 1, 1, 32'h0, 24'h0);
        step(0, 0, 1, 32'h0000_1234, 24'h001234);
        check_eq("fold", 64'(sig_a), 64'h26);

        // Toggle count, then clear.
        step(0, 1, 0, 32'h0, 24'h0);
        foreach (last_d[i]) if (i < 6) begin
            logic [31:0] seq[6];
            seq = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h0};
            step(0, 0, 1, seq[i], seq[i][23:0]);
        end
        check_eq("tog_cnt", 64'(cnt_a), ToggleEn ? 64'd2 : 64'd0);
        check_eq("tog_act", 64'(act_a), ToggleEn ? 64'd1 : 64'd0);
        step(0, 1, 1, 32'h77, 24'h77);
        check_eq("clr_cnt", 64'(cnt_a), 64'd0);
        check_eq("clr_act", 64'(act_a), 64'd0);
        check_eq("clr_sig", 64'(sig_a), 64'h00);

        // Saturation.
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, (i % 2) ? 32'hFF : 32'h00, (i % 2) ? 24'hFF : 24'h00);
        end
        check_eq("sat", 64'(cnt_a), ToggleEn ? 64'd15 : 64'd0);
        step(0, 0, 1, 32'h00, 24'h00);
        check_eq("sat_hold", 64'(cnt_a), ToggleEn ? 64'd15 : 64'd0);
        check_eq("sat_b", 64'(cnt_b), ToggleEn ? 64'd7 : 64'd0);

        // Enable gating: disabled changes are invisible when the data returns to its old value.
        step(0, 1, 0, 32'h0, 24'h0);
        step(0, 0, 1, 32'h00, 24'h00);
        step(0, 0, 0, 32'h55, 24'h55);
        step(0, 0, 0, 32'h00, 24'h00);
        step(0, 0, 1, 32'h00, 24'h00);
        check_eq("gate_cnt", 64'(cnt_a), 64'd0);
        check_eq("gate_sig", 64'(sig_a), 64'h00);

        // Reset and clear together.
        step(0, 0, 1, 32'h1234_5678, 24'h345678);
        step(1, 1, 1, 32'hFFFF_FFFF, 24'hFFFFFF);
        check_eq("rstclr_sig_b", 64'(sig_b), 64'h0A5A);
        check_eq("rstclr_cnt_b", 64'(cnt_b), 64'd0);

        // Random traffic with repeated data, so both toggles and holds occur.
        last_d = '0;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] nd;
            nd = ($urandom_range(0, 2) == 0) ? last_d : $urandom;
            last_d = nd;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0), nd, nd[31:8]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/unread_compactor.md
Name: unread_compactor

Overview:
- Parametrised sink for unused buses. Inputs that would otherwise be left open feed this block, which absorbs them and keeps them observable.
- Folds any number of unused channels into a multiple-input signature register (MISR) every enabled cycle.
- Optionally counts input activity.
- Sits at subsystem boundaries and in debug taps. Keeps lint clean and gives verification a compact signature of traffic on otherwise-dead wires.

Parameters:
- WIDTH, 32, bits per input channel (>=1)
- CHANNELS, 1, number of input channels (>=1)
- SIG_WIDTH, 32, signature register width (>=2)
- POLY, 32'h04C11DB7, MISR feedback polynomial; low SIG_WIDTH bits used
- SEED, '0, signature value after reset/clear; low SIG_WIDTH bits used
- CNT_WIDTH, 16, toggle counter width (>=1)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  synchronous reset, active-high
- en_i  input  1  compaction/monitor enable
- clear_i  input  1  synchronous clear of signature, counter, sticky flag
- d_i  input  CHANNELS*WIDTH  unused data; channel k = d_i[k*WIDTH +: WIDTH]
- signature_o  output  SIG_WIDTH  current MISR value
- toggle_cnt_o  output  CNT_WIDTH  cycles in which d_i changed, saturating
- active_o  output  1  sticky: d_i changed at least once since reset/clear

Behaviour:
- Reset (rst_i=1 at clock edge):
  - signature_o=SEED, toggle_cnt_o=0, active_o=0.
  - Internal prev_valid=0; prev register=0.
- Channel fold: ch = XOR of all CHANNELS channels (WIDTH bits).
- Width fold to SIG_WIDTH:
  - WIDTH<=SIG_WIDTH: zero-extend ch.
  - WIDTH>SIG_WIDTH: zero-pad ch to a multiple of SIG_WIDTH, then XOR all SIG_WIDTH-bit slices. The LSB slice is ch[SIG_WIDTH-1:0].
  - Result is f.
- MISR update, when en_i=1: sig <= (sig<<1, truncated to SIG_WIDTH) ^ (sig[MSB] ? POLY : 0) ^ f.
- Latency: d_i sampled at edge N appears in signature_o after edge N (1 cycle). Outputs are registered only; no combinational path from d_i.
- Toggle detect:
  - toggle = prev_valid && (d_i != prev). Compares the full CHANNELS*WIDTH vector, not the folded value.
  - On en_i=1: prev <= d_i, prev_valid <= 1.
  - If toggle: toggle_cnt_o increments by 1, saturating at 2^CNT_WIDTH-1 (holds, no wrap); active_o <= 1.
- en_i=0: all state holds, including prev and prev_valid. Toggles across disabled cycles are detected on the next enabled cycle against the last enabled sample.
- clear_i=1:
  - Same effect as reset on all state, regardless of en_i.
  - The d_i value that cycle is neither compacted nor captured.
- Priority: rst_i > clear_i > en_i.
- The first enabled cycle after reset/clear never counts a toggle.
- Reset or clear mid-stream discards all history; no partial signature is retained.

Optional Feature:
- Macro: UNREAD_COMPACTOR_TOGGLE_EN.
- Defined: toggle detection, toggle_cnt_o and active_o behave as above.
- Undefined:
  - prev/prev_valid/counter logic is not instantiated.
  - toggle_cnt_o is tied to 0 and active_o to 0.
  - Port list is unchanged; signature behaviour is identical.

Test Plan:
- Basic MISR (WIDTH=8, CHANNELS=1, SIG_WIDTH=8, POLY=8'h1D, SEED=0, en_i=1): after reset, drive d_i=0x01, 0x80, 0x00 on successive edges -> signature_o=0x01, 0x82, 0x19.
- Channel cancel (CHANNELS=2, WIDTH=8, SIG_WIDTH=8): drive d_i=16'hAAAA for 5 cycles from SEED=0 -> signature_o stays 0x00.
- Width fold (WIDTH=16, SIG_WIDTH=8, SEED=0): one enabled cycle with d_i=16'h1234 -> signature_o=0x26.
- Toggle count (TOGGLE_EN defined), with en_i=1:
  - After reset, d_i=0x00,0x00,0x00,0x01,0x01,0x00 -> toggle_cnt_o=2, active_o=1.
  - Then pulse clear_i with en_i=1 -> toggle_cnt_o=0, active_o=0, signature_o=SEED on the next cycle.
- Saturation (CNT_WIDTH=4): alternate d_i 0x00/0xFF for 20 enabled cycles -> toggle_cnt_o=15 and holds.
- Enable gating and priority:
  - en_i=0 while d_i changes 0x00->0x55->0x00 -> signature_o and toggle_cnt_o unchanged.
  - Next enabled cycle with d_i=0x00 -> no toggle counted.
  - rst_i and clear_i together -> reset values.
  - Macro undefined -> toggle_cnt_o=0 and active_o=0 throughout.
